// File: rtl/cocc_sequencer_if.sv
// cocc_sequencer_if
//   Control/bus bundle between the COCC sequencer and its datapath.
//   master : sequencer side (drives strobes, addresses and flags; reads run, bus and ALU status)
//   slave  : datapath / environment side
//   Signals:
//     run        1  leave FETCH when high
//     bus_in     DATA_W  shared data bus value as read back
//     alu_z/c    1  ALU zero/carry, valid while alu_oe=1
//     mem_oe, reg_oe, alu_oe   bus output-enables (at most one high)
//     reg_we     1  register file write strobe
//     reg_oaddr  3  register read address
//     reg_iaddr  3  register write address
//     alu_op     3  ALU function select
//     pc_inc     1  PC count-enable
//     pc_set     1  PC load from bus
//     flag_z/c   1  latched ALU flags
//     halted     1  sequencer in HALT
interface cocc_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              run;
  logic [DATA_W-1:0] bus_in;
  logic              alu_z;
  logic              alu_c;
  logic              mem_oe;
  logic              reg_oe;
  logic              alu_oe;
  logic              reg_we;
  logic [2:0]        reg_oaddr;
  logic [2:0]        reg_iaddr;
  logic [2:0]        alu_op;
  logic              pc_inc;
  logic              pc_set;
  logic              flag_z;
  logic              flag_c;
  logic              halted;

  modport master (
    input  run, bus_in, alu_z, alu_c,
    output mem_oe, reg_oe, alu_oe, reg_we, reg_oaddr, reg_iaddr, alu_op,
           pc_inc, pc_set, flag_z, flag_c, halted
  );

  modport slave (
    output run, bus_in, alu_z, alu_c,
    input  mem_oe, reg_oe, alu_oe, reg_we, reg_oaddr, reg_iaddr, alu_op,
           pc_inc, pc_set, flag_z, flag_c, halted
  );
endinterface

// File: rtl/cocc_sequencer.sv
// cocc_sequencer
//   Fetch/decode/execute control FSM for the COCC 8-bit datapath sharing one
//   tristate data bus. Holds IR and the Z/C flags. Memory is addressed by PC
//   on a separate path, so the sequencer only steers the bus and the PC.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; wins in every state
//     ctl    cocc_sequencer_if.master bundle (run, bus_in, alu_z/c in;
//            bus enables, register addresses/strobe, alu_op, pc_inc/pc_set,
//            flags and halted out)
//   ISA: IR[7:6]=op, IR[5:3]=d, IR[2:0]=s
//     00 MOV rd<-rs   01 LDI rd<-imm8   10 ALU rd<-alu(op=s)
//     11 d=000 JMP, d=001 JZ, d=010 JC (imm8 target), d=111 HLT, else NOP
//   DATA_W is fixed at 8 by the ISA field layout.
module cocc_sequencer #(
  parameter int unsigned        DATA_W   = 8,
  parameter logic [DATA_W-1:0]  IR_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  cocc_sequencer_if.master ctl
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] IMM    = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [2:0] SYS_JMP = 3'b000;
  localparam logic [2:0] SYS_JZ  = 3'b001;
  localparam logic [2:0] SYS_JC  = 3'b010;
  localparam logic [2:0] SYS_HLT = 3'b111;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [DATA_W-1:0] ir_q;
  logic              flag_z_q;
  logic              flag_c_q;

  logic [1:0] op;
  logic [2:0] fd;
  logic [2:0] fs;
  logic       jump_taken;

  assign op = ir_q[7:6];
  assign fd = ir_q[5:3];
  assign fs = ir_q[2:0];

  // Branch condition uses the flags as latched by the last ALU instruction.
  always_comb begin
    jump_taken = 1'b0;
    if (op == OP_SYS) begin
      case (fd)
        SYS_JMP: jump_taken = 1'b1;
        SYS_JZ:  jump_taken = flag_z_q;
        SYS_JC:  jump_taken = flag_c_q;
        default: jump_taken = 1'b0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (ctl.run) state_d = DECODE;
      end
      DECODE: begin
        case (op)
          OP_MOV, OP_ALU: state_d = EXEC;
          OP_LDI:         state_d = IMM;
          default: begin
            case (fd)
              SYS_JMP, SYS_JZ, SYS_JC: state_d = IMM;
              SYS_HLT:                 state_d = HALT;
              default:                 state_d = FETCH;
            endcase
          end
        endcase
      end
      EXEC:    state_d = FETCH;
      IMM:     state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      ir_q     <= IR_RESET;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && ctl.run) begin
        ir_q <= ctl.bus_in;
      end
      if (state_q == EXEC && op == OP_ALU) begin
        flag_z_q <= ctl.alu_z;
        flag_c_q <= ctl.alu_c;
      end
    end
  end

  // Strobes are decoded from state and IR only; the sole input that reaches
  // them is run, which gates the fetch cycle. bus_in never feeds an output.
  always_comb begin
    ctl.mem_oe    = 1'b0;
    ctl.reg_oe    = 1'b0;
    ctl.alu_oe    = 1'b0;
    ctl.reg_we    = 1'b0;
    ctl.reg_oaddr = '0;
    ctl.reg_iaddr = '0;
    ctl.alu_op    = '0;
    ctl.pc_inc    = 1'b0;
    ctl.pc_set    = 1'b0;
    ctl.halted    = 1'b0;
    case (state_q)
      FETCH: begin
        if (ctl.run) begin
          ctl.mem_oe = 1'b1;
          ctl.pc_inc = 1'b1;
        end
      end
      EXEC: begin
        ctl.reg_we    = 1'b1;
        ctl.reg_iaddr = fd;
        if (op == OP_ALU) begin
          ctl.alu_oe = 1'b1;
          ctl.alu_op = fs;
        end else begin
          ctl.reg_oe    = 1'b1;
          ctl.reg_oaddr = fs;
        end
      end
      IMM: begin
        // Operand byte is always on the bus; either consumed by LDI, loaded
        // into PC by a taken jump, or skipped by incrementing PC.
        ctl.mem_oe = 1'b1;
        if (op == OP_LDI) begin
          ctl.reg_we    = 1'b1;
          ctl.reg_iaddr = fd;
          ctl.pc_inc    = 1'b1;
        end else if (jump_taken) begin
          ctl.pc_set = 1'b1;
        end else begin
          ctl.pc_inc = 1'b1;
        end
      end
      HALT: begin
        ctl.halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ctl.flag_z = flag_z_q;
  assign ctl.flag_c = flag_c_q;

endmodule

// File: tb/tb_cocc_sequencer.sv
// tb_cocc_sequencer
//   Directed plus random-instruction bench for cocc_sequencer. The reference
//   model walks each instruction through the cycle sequence the ISA defines
//   (fetch, decode, then execute/operand/halt) and tracks Z/C at the
//   instruction level.
module tb_cocc_sequencer;

  typedef struct packed {
    logic       mem_oe;
    logic       reg_oe;
    logic       alu_oe;
    logic       reg_we;
    logic [2:0] oaddr;
    logic [2:0] iaddr;
    logic [2:0] alu_op;
    logic       pc_inc;
    logic       pc_set;
    logic       fz;
    logic       fc;
    logic       halted;
  } sig_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic mz;
  logic mc;

  cocc_sequencer_if #(.DATA_W(8)) ifc ();

  cocc_sequencer #(.DATA_W(8), .IR_RESET(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sig_t base();
    sig_t e;
    e    = '0;
    e.fz = mz;
    e.fc = mc;
    return e;
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // 1 time unit later, well away from the rising edge.
  task automatic cyc(input logic r, input logic [7:0] b, input logic az,
                     input logic ac, input sig_t e, input string tag,
                     input logic rst);
    sig_t o;
    @(negedge clk);
    reset      = rst;
    ifc.run    = r;
    ifc.bus_in = b;
    ifc.alu_z  = az;
    ifc.alu_c  = ac;
    #1;
    o = {ifc.mem_oe, ifc.reg_oe, ifc.alu_oe, ifc.reg_we, ifc.reg_oaddr,
         ifc.reg_iaddr, ifc.alu_op, ifc.pc_inc, ifc.pc_set, ifc.flag_z,
         ifc.flag_c, ifc.halted};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    checks++;
    assert (($countones({ifc.mem_oe, ifc.reg_oe, ifc.alu_oe}) <= 1) &&
            !(ifc.pc_inc && ifc.pc_set)) else begin
      failures++;
      $error("FAIL %s_invariant observed=oe:%b%b%b inc/set:%b%b expected=onehot0/exclusive",
             tag, ifc.mem_oe, ifc.reg_oe, ifc.alu_oe, ifc.pc_inc, ifc.pc_set);
    end
  endtask

  task automatic hold(input string tag);
    cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), base(), tag, 1'b0);
  endtask

  task automatic start_reset();
    @(negedge clk);
    reset   = 1'b1;
    ifc.run = 1'($urandom);
    mz      = 1'b0;
    mc      = 1'b0;
  endtask

  // Runs one instruction; returns 1 if it was HLT (sequencer now in HALT).
  task automatic do_instr(input logic [7:0] ir, input logic [7:0] opnd,
                          input logic az, input logic ac, input bit rnd_run,
                          output bit is_halt);
    sig_t e;
    logic [1:0] op;
    logic [2:0] d;
    logic [2:0] s;
    logic rr;
    bit taken;
    op = ir[7:6];
    d  = ir[5:3];
    s  = ir[2:0];
    is_halt = 1'b0;

    e = base(); e.mem_oe = 1'b1; e.pc_inc = 1'b1;
    cyc(1'b1, ir, 1'($urandom), 1'($urandom), e, "fetch", 1'b0);

    rr = rnd_run ? 1'($urandom) : 1'b1;
    cyc(rr, 8'($urandom), 1'($urandom), 1'($urandom), base(), "decode", 1'b0);

    rr = rnd_run ? 1'($urandom) : 1'b1;
    if (op == 2'b00) begin
      e = base(); e.reg_oe = 1'b1; e.oaddr = s; e.reg_we = 1'b1; e.iaddr = d;
      cyc(rr, 8'($urandom), 1'($urandom), 1'($urandom), e, "exec_mov", 1'b0);
    end else if (op == 2'b10) begin
      e = base(); e.alu_oe = 1'b1; e.alu_op = s; e.reg_we = 1'b1; e.iaddr = d;
      cyc(rr, 8'($urandom), az, ac, e, "exec_alu", 1'b0);
      mz = az;
      mc = ac;
    end else if (op == 2'b01) begin
      e = base(); e.mem_oe = 1'b1; e.reg_we = 1'b1; e.iaddr = d; e.pc_inc = 1'b1;
      cyc(rr, opnd, 1'($urandom), 1'($urandom), e, "imm_ldi", 1'b0);
    end else if (d == 3'd0 || d == 3'd1 || d == 3'd2) begin
      taken = (d == 3'd0) || (d == 3'd1 && mz) || (d == 3'd2 && mc);
      e = base(); e.mem_oe = 1'b1; e.pc_set = taken; e.pc_inc = !taken;
      cyc(rr, opnd, 1'($urandom), 1'($urandom), e, "imm_jump", 1'b0);
    end else if (d == 3'd7) begin
      is_halt = 1'b1;
    end
  endtask

  initial begin
    sig_t e;
    bit   hl;
    logic [7:0] ir;
    checks     = 0;
    failures   = 0;
    mz         = 1'b0;
    mc         = 1'b0;
    reset      = 1'b1;
    ifc.run    = 1'b0;
    ifc.bus_in = '0;
    ifc.alu_z  = 1'b0;
    ifc.alu_c  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state and FETCH hold with run=0
    hold("reset_state");
    hold("fetch_hold");

    // 1: LDI r1, 0x5C
    do_instr(8'h4A, 8'h5C, 1'b0, 1'b0, 1'b0, hl);
    // 2: MOV r2, r3
    do_instr(8'h13, 8'h00, 1'b0, 1'b0, 1'b0, hl);
    // 3: ALU op5 into r0 with Z=1 C=0, then JZ taken
    do_instr(8'h85, 8'h00, 1'b1, 1'b0, 1'b0, hl);
    do_instr(8'hC8, 8'h20, 1'b0, 1'b0, 1'b0, hl);
    // 4: JC not taken, then a following FETCH
    do_instr(8'hD0, 8'h40, 1'b0, 1'b0, 1'b0, hl);
    do_instr(8'hDB, 8'h00, 1'b0, 1'b0, 1'b0, hl);  // 1-byte NOP
    // JC taken after an ALU sets C
    do_instr(8'hAE, 8'h00, 1'b0, 1'b1, 1'b0, hl);
    do_instr(8'hD0, 8'h33, 1'b0, 1'b0, 1'b0, hl);

    // 5: HLT, 20 cycles halted regardless of inputs, then reset
    do_instr(8'hF8, 8'h00, 1'b0, 1'b0, 1'b0, hl);
    for (int unsigned i = 0; i < 20; i++) begin
      e = base(); e.halted = 1'b1;
      cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), e, "halted", 1'b0);
    end
    start_reset();
    hold("halt_reset");

    // 6: reset during the operand cycle of LDI
    e = base(); e.mem_oe = 1'b1; e.pc_inc = 1'b1;
    cyc(1'b1, 8'h4A, 1'b0, 1'b0, e, "fetch", 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, base(), "decode", 1'b0);
    e = base(); e.mem_oe = 1'b1; e.reg_we = 1'b1; e.iaddr = 3'd1; e.pc_inc = 1'b1;
    cyc(1'b1, 8'h5C, 1'b0, 1'b0, e, "imm_ldi_at_reset", 1'b1);
    mz = 1'b0;
    mc = 1'b0;
    hold("mid_instr_reset");

    // Random instruction stream with run toggling mid-instruction and hold gaps
    for (int unsigned n = 0; n < 150; n++) begin
      ir = 8'($urandom);
      if (ir[7:6] == 2'b11 && ir[5:3] == 3'b111) ir[5:3] = 3'b011;
      if ($urandom_range(3, 0) == 0) hold("rand_hold");
      do_instr(ir, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, hl);
    end

    // Final halt after random history keeps flags
    do_instr(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, hl);
    for (int unsigned i = 0; i < 3; i++) begin
      e = base(); e.halted = 1'b1;
      cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), e, "halted_end", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
